// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and bus-level constants.
`timescale 1ns/1ps
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        ADDR_ACK = 4'd2,
        WR_DATA  = 4'd3,
        WR_ACK   = 4'd4,
        RD_DATA  = 4'd5,
        RD_ACK   = 4'd6,
        RD_LOAD  = 4'd7,
        IGNORE   = 4'd8
    } state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_target_slave_if.sv
// Pad and local sink/source signals of the I2C target, seen from the bus side (master)
// and from the block itself (slave).
`timescale 1ns/1ps
interface i2c_target_slave_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic       busy;
    logic       addr_match;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       nack_seen;

    modport slave (
        input  scl_i, sda_i, rd_data,
        output sda_oe, busy, addr_match, wr_valid, wr_data, rd_req, nack_seen
    );

    modport master (
        output scl_i, sda_i, rd_data,
        input  sda_oe, busy, addr_match, wr_valid, wr_data, rd_req, nack_seen
    );
endinterface

// File: rtl/i2c_sync_edge.sv
// Synchroniser for one open-drain pad input plus single-cycle rise/fall strobes.
`timescale 1ns/1ps
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Preset to 1 so a released (idle) bus produces no edge when reset lifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_target_slave.sv
// 7-bit-address I2C target: START/STOP detection, address match, write sink pulses
// and read source handshake. SDA is only ever pulled low, and only changes on SCL fall.
`timescale 1ns/1ps
module i2c_target_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    i2c_target_slave_if.slave    bus
);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .rst_n(rst_n), .din(bus.scl_i),
        .level(scl_s), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .rst_n(rst_n), .din(bus.sda_i),
        .level(sda_s), .rise(sda_rise), .fall(sda_fall)
    );

    state_e     state;
    logic [2:0] bitcnt;
    logic [7:0] shifter;
    logic       rw;
    logic       ack_phase;
    logic       sda_oe_q;
    logic       addr_match_q, wr_valid_q, rd_req_q, nack_seen_q;
    logic [7:0] wr_data_q;

    logic       start_cond, stop_cond;
    logic [7:0] shift_nxt;

    assign start_cond = sda_fall & scl_s;
    assign stop_cond  = sda_rise & scl_s;
    assign shift_nxt  = {shifter[6:0], sda_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bitcnt       <= 3'd7;
            shifter      <= 8'h00;
            rw           <= I2C_RW_WRITE;
            ack_phase    <= 1'b0;
            sda_oe_q     <= 1'b0;
            addr_match_q <= 1'b0;
            wr_valid_q   <= 1'b0;
            rd_req_q     <= 1'b0;
            nack_seen_q  <= 1'b0;
            wr_data_q    <= 8'h00;
        end else begin
            addr_match_q <= 1'b0;
            wr_valid_q   <= 1'b0;
            rd_req_q     <= 1'b0;
            nack_seen_q  <= 1'b0;

            // Bus conditions override any bit-level activity in every state.
            if (start_cond) begin
                sda_oe_q  <= 1'b0;
                bitcnt    <= 3'd7;
                shifter   <= 8'h00;
                ack_phase <= 1'b0;
                state     <= ADDR;
            end else if (stop_cond) begin
                sda_oe_q  <= 1'b0;
                ack_phase <= 1'b0;
                state     <= IDLE;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shifter <= shift_nxt;
                        if (bitcnt == 3'd0) begin
                            if (shift_nxt[7:1] == SLAVE_ADDR) begin
                                addr_match_q <= 1'b1;
                                rw           <= shift_nxt[0];
                                rd_req_q     <= (shift_nxt[0] == I2C_RW_READ);
                                ack_phase    <= 1'b0;
                                state        <= ADDR_ACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end else begin
                            bitcnt <= bitcnt - 3'd1;
                        end
                    end

                    ADDR_ACK: if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe_q  <= 1'b1;
                            ack_phase <= 1'b1;
                        end else begin
                            ack_phase <= 1'b0;
                            bitcnt    <= 3'd7;
                            if (rw == I2C_RW_READ) begin
                                shifter  <= bus.rd_data;
                                sda_oe_q <= ~bus.rd_data[7];
                                state    <= RD_DATA;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state    <= WR_DATA;
                            end
                        end
                    end

                    WR_DATA: if (scl_rise) begin
                        shifter <= shift_nxt;
                        if (bitcnt == 3'd0) begin
                            wr_data_q  <= shift_nxt;
                            wr_valid_q <= 1'b1;
                            ack_phase  <= 1'b0;
                            state      <= WR_ACK;
                        end else begin
                            bitcnt <= bitcnt - 3'd1;
                        end
                    end

                    WR_ACK: if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe_q  <= 1'b1;
                            ack_phase <= 1'b1;
                        end else begin
                            sda_oe_q  <= 1'b0;
                            ack_phase <= 1'b0;
                            bitcnt    <= 3'd7;
                            state     <= WR_DATA;
                        end
                    end

                    // The MSB went out when the byte was loaded; each later fall presents the next bit.
                    RD_DATA: if (scl_fall) begin
                        if (bitcnt == 3'd0) begin
                            sda_oe_q <= 1'b0;
                            state    <= RD_ACK;
                        end else begin
                            bitcnt   <= bitcnt - 3'd1;
                            shifter  <= {shifter[6:0], 1'b0};
                            sda_oe_q <= ~shifter[6];
                        end
                    end

                    RD_ACK: if (scl_rise) begin
                        if (sda_s == I2C_ACK) begin
                            rd_req_q <= 1'b1;
                            state    <= RD_LOAD;
                        end else begin
                            nack_seen_q <= 1'b1;
                            state       <= IGNORE;
                        end
                    end

                    RD_LOAD: if (scl_fall) begin
                        shifter  <= bus.rd_data;
                        sda_oe_q <= ~bus.rd_data[7];
                        bitcnt   <= 3'd7;
                        state    <= RD_DATA;
                    end

                    IGNORE: sda_oe_q <= 1'b0;

                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.sda_oe     = sda_oe_q;
    assign bus.busy       = (state != IDLE);
    assign bus.addr_match = addr_match_q;
    assign bus.wr_valid   = wr_valid_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.rd_req     = rd_req_q;
    assign bus.nack_seen  = nack_seen_q;

endmodule

// File: tb/tb_i2c_target_slave.sv
// Directed bench for i2c_target_slave: a bit-banged bus master, a read-data source
// and a scoreboard of expected write/read bytes.
`timescale 1ns/1ps
module tb_i2c_target_slave;

    localparam time Q = 80ns;

    logic clk;
    logic rst_n;
    logic scl_m;
    logic sda_m;

    int tests = 0;
    int fails = 0;

    int n_am, n_wr, n_rr, n_nk;
    bit oe_seen, busy_low;

    logic [7:0] wr_exp[$];
    logic [7:0] rd_exp[$];
    logic [7:0] src_q[$];

    i2c_target_slave_if bus();

    i2c_target_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Read-data source: answers each rd_req one clock later.
    initial begin
        bus.rd_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rd_req) begin
                if (src_q.size() != 0) bus.rd_data = src_q.pop_front();
                else                   bus.rd_data = 8'hEE;
            end
        end
    end

    // Output monitor and write-side scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.addr_match) n_am++;
                if (bus.rd_req)     n_rr++;
                if (bus.nack_seen)  n_nk++;
                if (bus.sda_oe)     oe_seen = 1'b1;
                if (!bus.busy)      busy_low = 1'b1;
                if (bus.wr_valid) begin
                    n_wr++;
                    check("wr_exp_avail", (wr_exp.size() != 0), 1);
                    if (wr_exp.size() != 0) check("wr_data", bus.wr_data, wr_exp.pop_front());
                end
            end
        end
    end

    task automatic clr_counts();
        n_am = 0; n_wr = 0; n_rr = 0; n_nk = 0;
        oe_seen = 1'b0; busy_low = 1'b0;
    endtask

    function automatic logic [13:0] outs();
        return {bus.sda_oe, bus.busy, bus.addr_match, bus.wr_valid,
                bus.rd_req, bus.nack_seen, bus.wr_data};
    endfunction

    task automatic bit_xfer(input logic b, output logic s);
        sda_m = b;
        #Q; scl_m = 1'b1;
        #Q; s = bus.sda_i;
        #Q; scl_m = 1'b0;
        #Q;
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        #Q; scl_m = 1'b1;
        #Q; sda_m = 1'b0;
        #Q; scl_m = 1'b0;
        #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        #Q; scl_m = 1'b1;
        #Q; sda_m = 1'b1;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(ack_bit, s);
    endtask

    task automatic push_src(input logic [7:0] b);
        src_q.push_back(b);
        rd_exp.push_back(b);
    endtask

    task automatic check_rd(input string tag, input logic [7:0] d);
        check({tag, "_avail"}, (rd_exp.size() != 0), 1);
        if (rd_exp.size() != 0) check(tag, d, rd_exp.pop_front());
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        logic       s;

        scl_m = 1'b1;
        sda_m = 1'b1;
        rst_n = 1'b0;
        clr_counts();
        repeat (4) @(negedge clk);
        check("reset_outputs", outs(), 14'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_outputs", outs(), 14'h0);

        // Write 0xA5 to 0x50
        clr_counts();
        bus_start();
        check("wr_busy", bus.busy, 1'b1);
        write_byte(8'hA0, ack);
        check("wr_addr_ack", ack, 1'b0);
        wr_exp.push_back(8'hA5);
        write_byte(8'hA5, ack);
        check("wr_data_ack", ack, 1'b0);
        bus_stop();
        check("wr_busy_after_stop", bus.busy, 1'b0);
        check("wr_addr_match_cnt", n_am, 1);
        check("wr_valid_cnt", n_wr, 1);

        // Wrong address 0x51
        clr_counts();
        bus_start();
        write_byte(8'hA2, ack);
        check("bad_addr_nack", ack, 1'b1);
        write_byte(8'hFF, ack);
        check("bad_data_nack", ack, 1'b1);
        check("bad_busy_ignore", bus.busy, 1'b1);
        bus_stop();
        check("bad_busy_after_stop", bus.busy, 1'b0);
        check("bad_sda_driven", oe_seen, 1'b0);
        check("bad_addr_match_cnt", n_am, 0);
        check("bad_wr_valid_cnt", n_wr, 0);

        // Read 0x3C (ACK) then 0xC3 (NACK)
        clr_counts();
        push_src(8'h3C);
        push_src(8'hC3);
        bus_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", ack, 1'b0);
        read_byte(1'b0, d);
        check_rd("rd_byte0", d);
        read_byte(1'b1, d);
        check_rd("rd_byte1", d);
        bus_stop();
        check("rd_addr_match_cnt", n_am, 1);
        check("rd_req_cnt", n_rr, 2);
        check("rd_nack_cnt", n_nk, 1);
        check("rd_busy_after_stop", bus.busy, 1'b0);

        // Write 0x11 then repeated START into a read of 0x77
        clr_counts();
        bus_start();
        busy_low = 1'b0;
        write_byte(8'hA0, ack);
        check("rs_addr_ack", ack, 1'b0);
        wr_exp.push_back(8'h11);
        write_byte(8'h11, ack);
        check("rs_data_ack", ack, 1'b0);
        push_src(8'h77);
        bus_start();
        write_byte(8'hA1, ack);
        check("rs_raddr_ack", ack, 1'b0);
        read_byte(1'b1, d);
        check_rd("rs_rd_byte", d);
        check("rs_busy_held", busy_low, 1'b0);
        bus_stop();
        check("rs_addr_match_cnt", n_am, 2);
        check("rs_wr_valid_cnt", n_wr, 1);
        check("rs_rd_req_cnt", n_rr, 1);

        // STOP after 4 data bits, then a full write of 0x5A
        clr_counts();
        bus_start();
        write_byte(8'hA0, ack);
        for (int i = 7; i >= 4; i--) bit_xfer(d[i], s);
        bus_stop();
        check("part_wr_valid_cnt", n_wr, 0);
        check("part_busy", bus.busy, 1'b0);
        bus_start();
        write_byte(8'hA0, ack);
        wr_exp.push_back(8'h5A);
        write_byte(8'h5A, ack);
        check("part_next_ack", ack, 1'b0);
        bus_stop();
        check("part_next_wr_cnt", n_wr, 1);

        // Reset while driving a read bit low
        clr_counts();
        push_src(8'h00);
        bus_start();
        write_byte(8'hA1, ack);
        check("rst_addr_ack", ack, 1'b0);
        check("rst_pre_sda_oe", bus.sda_oe, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_sda_oe", bus.sda_oe, 1'b0);
        check("rst_async_outputs", outs(), 14'h0);
        sda_m = 1'b1;
        scl_m = 1'b1;
        src_q.delete();
        rd_exp.delete();
        wr_exp.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        clr_counts();
        bus_start();
        write_byte(8'hA0, ack);
        check("post_rst_addr_ack", ack, 1'b0);
        wr_exp.push_back(8'h33);
        write_byte(8'h33, ack);
        bus_stop();
        check("post_rst_wr_cnt", n_wr, 1);
        check("post_rst_busy", bus.busy, 1'b0);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
